// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the register/bus decoder.
// First-word-fall-through head, occupancy count, sticky overrun and level irq.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_W  = 4,
    parameter int unsigned THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_end_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rd_en_i,
    input  logic             ovr_clr_i,
    output logic [7:0]       rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [PTR_W:0]   count_o,
    output logic             overrun_o,
    output logic             irq_o
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             irq_q, irq_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        empty_o   = (count_q == '0);
        full_o    = (count_q == (PTR_W+1)'(DEPTH));
        rd_ok     = rd_en_i & ~empty_o;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        wr_ok     = rx_end_i & (~full_o | rd_ok);

        wr_ptr_d  = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d   = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        overrun_d = overrun_q;
        if (rx_end_i & ~wr_ok) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end

        irq_d     = (count_d >= (PTR_W+1)'(THRESH)) | overrun_d;

        rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];
        count_o   = count_q;
        overrun_o = overrun_q;
        irq_o     = irq_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    // Storage carries no reset; empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table plus corner sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       irq;

    int tests = 0;
    int fails = 0;

    uart_rx_fifo #(
        .DEPTH (16),
        .PTR_W (4),
        .THRESH(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_end_i (rx_end),
        .rx_data_i(rx_data),
        .rd_en_i  (rd_en),
        .ovr_clr_i(ovr_clr),
        .rd_data_o(rd_data),
        .empty_o  (empty),
        .full_o   (full),
        .count_o  (count),
        .overrun_o(overrun),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rx_end;
        logic [7:0] rx_data;
        logic       rd_en;
        logic       ovr_clr;
        int         count;
        logic       empty;
        logic       full;
        logic [7:0] rd_data;
        logic       overrun;
        logic       irq;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input logic e, input logic f,
                           input logic [7:0] d, input logic o, input logic i);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".empty"}, int'(empty), int'(e));
        chk({tag, ".full"}, int'(full), int'(f));
        chk({tag, ".rd_data"}, int'(rd_data), int'(d));
        chk({tag, ".overrun"}, int'(overrun), int'(o));
        chk({tag, ".irq"}, int'(irq), int'(i));
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic cyc(input logic we, input logic [7:0] d, input logic re, input logic oc);
        rx_end  = we;
        rx_data = d;
        rd_en   = re;
        ovr_clr = oc;
        @(posedge clk);
        #1;
        rx_end  = 1'b0;
        rd_en   = 1'b0;
        ovr_clr = 1'b0;
        rx_data = 8'h00;
    endtask

    byte unsigned q[$];
    byte unsigned b;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h22, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; rx_end = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].rx_end, vecs[i].rx_data, vecs[i].rd_en, vecs[i].ovr_clr);
            chk_all($sformatf("vec%0d", i), vecs[i].count, vecs[i].empty, vecs[i].full,
                    vecs[i].rd_data, vecs[i].overrun, vecs[i].irq);
        end

        // Fill to full, drop one byte, drain in order.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk_all("fill16", 16, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_all("drop", 16, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), int'(rd_data), i);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_all("drained", 0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_all("ovr_clr", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk_all("full_rw", 16, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_rw_rd%0d", i), int'(rd_data), (i == 15) ? 8'h55 : 8'h11 + i);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("full_rw_empty", int'(empty), 1);

        // Overrun set wins over a coincident clear.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovr_set", int'(overrun), 1);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("ovr_set_wins", int'(overrun), 1);
        chk("ovr_set_wins.count", int'(count), 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_clr_alone", int'(overrun), 0);
        chk("ovr_clr_alone.count", int'(count), 16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovr_drained", int'(count), 0);

        // Pointer wrap: keep three in flight across 40 push/pop pairs.
        for (int i = 0; i < 3; i++) begin
            b = 8'(8'hC0 + i);
            q.push_back(b);
            cyc(1'b1, b, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            b = 8'((i * 37 + 5) & 8'hFF);
            chk($sformatf("wrap%0d", i), int'(rd_data), int'(q[0]));
            void'(q.pop_front());
            q.push_back(b);
            cyc(1'b1, b, 1'b1, 1'b0);
        end
        chk("wrap.count", int'(count), 3);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        chk("pre_reset.count", int'(count), 5);

        // Asynchronous reset mid-stream; a coincident rx_end is lost.
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        rx_end  = 1'b1;
        rx_data = 8'h9A;
        @(posedge clk);
        #1;
        rx_end = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
